zigzag_buf: RTL and testbench
=============================

ZIGZAG_BUF -- requirements
Module: zigzag_buf

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is asynchronous and active-high, named rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in  input  32  DCT coefficient from the transpose/column-DCT stage, raster (row-major) order.
REQ-005 in_valid  input  1  in carries a coefficient this cycle.
REQ-006 in_ready  output  1  block can accept a coefficient this cycle.
REQ-007 O  output  32  registered coefficient in zigzag order.
REQ-008 out_valid  output  1  O, out_index and out_last are valid.
REQ-009 out_ready  input  1  downstream (quantizer/entropy coder) accepts O this cycle.
REQ-010 out_index  output  6  zigzag position 0..63 of the coefficient on O.
REQ-011 out_last  output  1  high with out_index==63.

Function
REQ-012 The block SHALL hold two 64x32 banks (ping-pong); a bank is FILLING, FULL or DRAINING.
REQ-013 Write side: bank pointer wb (1 bit), counter wcnt (6 bits); in_ready = !full[wb], combinational from registered state only.
REQ-014 Accept = in_valid && in_ready at a rising edge: bank[wb][wcnt] <= in, wcnt <= wcnt+1.
REQ-015 The k-th accepted sample of a block (k=0..63) SHALL be coefficient row k/8, column k%8, raster address k.
REQ-016 On accepting with wcnt==63: full[wb] <= 1, wb toggles, wcnt wraps to 0.
REQ-017 in_valid while in_ready==0 SHALL write nothing and change no write state; the upstream holds in.
REQ-018 Read side: bank pointer rb, counter rcnt (6 bits); output register advances when (!out_valid || out_ready).
REQ-019 When advancing and full[rb]==1: O <= bank[rb][ZZ(rcnt)], out_index <= rcnt, out_last <= (rcnt==63), out_valid <= 1, rcnt <= rcnt+1.
REQ-020 When advancing with rcnt==63: full[rb] <= 0, rb toggles, rcnt wraps to 0, in the same edge.
REQ-021 When advancing and full[rb]==0: out_valid <= 0; O, out_index and out_last hold.
REQ-022 With out_valid==1 and out_ready==0, O, out_index, out_last and out_valid SHALL hold unchanged.
REQ-023 ZZ SHALL be the JPEG zigzag table, raster addresses for positions 0..63: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
REQ-024 Latency: 64th sample accepted at edge t; out_valid=1 with out_index=0 after edge t+1.
REQ-025 Throughput: with out_ready held 1 and in_valid held 1, in_ready SHALL never deassert; one coefficient in and one out per cycle sustained.
REQ-026 Setting full on one bank and clearing full on the other in the same edge SHALL both take effect.
REQ-027 Both banks FULL: in_ready=0 until the draining bank clears full at its 64th output advance; in_ready=1 the cycle after.
REQ-028 Data is passed unmodified; no arithmetic on coefficient values.

Reset
REQ-029 rst=1 SHALL immediately force: wb=rb=0, wcnt=rcnt=0, full[1:0]=0, O=0, out_index=0, out_last=0, out_valid=0; hence in_ready=1.
REQ-030 Bank contents SHALL NOT be reset; any partially written or partially drained block is discarded.
REQ-031 After rst deasserts, the next accepted sample SHALL be raster address 0 of bank 0.

Verification
REQ-032 Single block: in=k for k=0..63, out_ready=1 -> O sequence 0,1,8,16,9,2,...,55,62,63; out_index 0..63; out_last only on 63.
REQ-033 Back-to-back: three blocks in=256*b+k continuous, out_ready=1 -> in_ready never 0; outputs of block b in zigzag order, blocks in order 0,1,2.
REQ-034 Backpressure: out_ready=0 for 200 cycles during block 0 drain, input continuous -> in_ready drops after block 1 fills; no loss, O held stable while stalled.
REQ-035 Random stalls: random in_valid/out_ready over 20 blocks -> output matches zigzag model exactly, out_last every 64th transfer.
REQ-036 Reset mid-block: rst after 30 inputs -> all outputs zero immediately, in_ready=1; next 64 inputs form a clean block 0 from bank 0.

Source files
------------

// File: rtl/zigzag_buf.sv
// Ping-pong 64-coefficient buffer: raster-order writes, JPEG zigzag-order registered reads.
// First output one edge after a bank fills; in_ready drops only while both banks are full.
module zigzag_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] O,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic        out_last
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [31:0] bank [128];
  logic        wb;
  logic        rb;
  logic [5:0]  wcnt;
  logic [5:0]  rcnt;
  logic [1:0]  full;
  logic        wr_fire;
  logic        rd_adv;

  assign in_ready = !full[wb];
  assign wr_fire  = in_valid && in_ready;
  assign rd_adv   = !out_valid || out_ready;

  // Storage is deliberately not reset; the full flags decide what is live.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank[{wb, wcnt}] <= in;
    end
  end

  // Writer only touches a non-full bank and reader only a full one, so the
  // set and clear of full never target the same bit in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= 6'd0;
      rcnt      <= 6'd0;
      full      <= 2'b00;
      O         <= 32'd0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == 6'd63) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end
      end
      if (rd_adv) begin
        if (full[rb]) begin
          O         <= bank[{rb, ZZ[rcnt]}];
          out_index <= rcnt;
          out_last  <= (rcnt == 6'd63);
          out_valid <= 1'b1;
          rcnt      <= rcnt + 6'd1;
          if (rcnt == 6'd63) begin
            full[rb] <= 1'b0;
            rb       <= ~rb;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_zigzag_buf.sv
// Bench for zigzag_buf: scoreboard fed by observed input handshakes, zigzag order
// derived from anti-diagonal walks; table vectors plus directed multi-cycle sequences.
module tb_zigzag_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] O;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic        out_last;

  always #5 clk = ~clk;

  zigzag_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .O         (O),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last)
  );

  typedef struct {
    int          pos;
    logic [31:0] val;
    logic        last;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          zz_model [64];
  logic [31:0] blk_buf [64];
  int          blk_fill = 0;
  logic [31:0] exp_q [$];
  logic [31:0] cap_o [$];
  logic        cap_l [$];
  int          out_cnt  = 0;
  int          n_last   = 0;
  int          sent     = 0;
  int          n_lim    = 0;
  int          rdy_low  = 0;
  logic [31:0] stim [2048];
  logic [31:0] prev_o;
  logic [5:0]  prev_idx;
  logic        prev_last;
  logic        prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Zigzag = walk anti-diagonals r+c=s, alternating direction; even s walks up (row decreasing).
  function automatic void build_zz();
    int p;
    int lo;
    int hi;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_model[p] = r * 8 + (s - r); p++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_model[p] = r * 8 + (s - r); p++; end
      end
    end
  endfunction

  // Inputs change just after posedge, so a negedge sample is what the next edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      blk_fill   = 0;
      exp_q.delete();
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_o", 64'(O), 64'(prev_o));
        check("hold_index", 64'(out_index), 64'(prev_idx));
        check("hold_last", 64'(out_last), 64'(prev_last));
        check("hold_valid", 64'(out_valid), 64'(1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          check("data", 64'(O), 64'(exp_q.pop_front()));
        end
        check("index", 64'(out_index), 64'(out_cnt % 64));
        check("last", 64'(out_last), 64'((out_cnt % 64) == 63));
        cap_o.push_back(O);
        cap_l.push_back(out_last);
        if (out_last) n_last++;
        out_cnt++;
      end
      if (!in_ready) rdy_low++;
      if (in_valid && in_ready) begin
        blk_buf[blk_fill] = in;
        blk_fill++;
        sent++;
        if (blk_fill == 64) begin
          for (int p = 0; p < 64; p++) exp_q.push_back(blk_buf[zz_model[p]]);
          blk_fill = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = O;
      prev_idx   = out_index;
      prev_last  = out_last;
    end
  end

  task automatic step(input logic vin, input logic rdy);
    @(posedge clk);
    #1;
    in        = stim[sent];
    in_valid  = vin && (sent < n_lim);
    out_ready = rdy;
  endtask

  task automatic run(input int pv_in, input int pv_out, input int max_cyc, input string name);
    int c = 0;
    while ((sent < n_lim || exp_q.size() != 0) && c < max_cyc) begin
      step($urandom_range(99, 0) < pv_in, $urandom_range(99, 0) < pv_out);
      c++;
    end
    check({name, "_timeout"}, 64'(c < max_cyc), 64'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_idle"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [14];
    int   base;

    vecs[0]  = '{0,  32'd0,  1'b0};
    vecs[1]  = '{1,  32'd1,  1'b0};
    vecs[2]  = '{2,  32'd8,  1'b0};
    vecs[3]  = '{3,  32'd16, 1'b0};
    vecs[4]  = '{4,  32'd9,  1'b0};
    vecs[5]  = '{5,  32'd2,  1'b0};
    vecs[6]  = '{20, 32'd40, 1'b0};
    vecs[7]  = '{27, 32'd6,  1'b0};
    vecs[8]  = '{28, 32'd7,  1'b0};
    vecs[9]  = '{35, 32'd56, 1'b0};
    vecs[10] = '{36, 32'd57, 1'b0};
    vecs[11] = '{61, 32'd55, 1'b0};
    vecs[12] = '{62, 32'd62, 1'b0};
    vecs[13] = '{63, 32'd63, 1'b1};

    build_zz();
    rst = 1'b1; in = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o", 64'(O), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;

    // Single block, raster values k; check latency then table of zigzag positions.
    for (int k = 0; k < 64; k++) stim[k] = 32'(k);
    sent = 0; n_lim = 64;
    cap_o.delete(); cap_l.delete();
    repeat (65) step(1'b1, 1'b1);
    check("lat_not_yet", 64'(out_valid), 64'(0));
    step(1'b0, 1'b1);
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_index", 64'(out_index), 64'(0));
    check("lat_o", 64'(O), 64'(0));
    run(0, 100, 500, "single");
    check("single_count", 64'(cap_o.size()), 64'(64));
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pos < cap_o.size()) begin
        check($sformatf("vec_o[%0d]", vecs[i].pos), 64'(cap_o[vecs[i].pos]), 64'(vecs[i].val));
        check($sformatf("vec_last[%0d]", vecs[i].pos), 64'(cap_l[vecs[i].pos]), 64'(vecs[i].last));
      end else begin
        check($sformatf("vec_missing[%0d]", vecs[i].pos), 64'(0), 64'(1));
      end
    end

    // Back-to-back blocks with no stalls: in_ready must stay high throughout.
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 64; k++) stim[b * 64 + k] = 32'(256 * b + k);
    sent = 0; n_lim = 192; rdy_low = 0; base = out_cnt;
    run(100, 100, 1000, "b2b");
    check("b2b_in_ready_low", 64'(rdy_low), 64'(0));
    check("b2b_count", 64'(out_cnt - base), 64'(192));

    // Output stalled 200 cycles: both banks fill, then release and time in_ready recovery.
    for (int i = 0; i < 192; i++) stim[i] = 32'(1000 + i);
    sent = 0; n_lim = 192;
    repeat (200) step(1'b1, 1'b0);
    check("bp_accepted", 64'(sent), 64'(128));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_o", 64'(O), 64'(1000));
    repeat (63) step(1'b1, 1'b1);
    check("bp_rdy_still_low", 64'(in_ready), 64'(0));
    step(1'b1, 1'b1);
    check("bp_rdy_back", 64'(in_ready), 64'(1));
    run(100, 100, 1000, "bp");

    // Random handshakes over 20 blocks.
    for (int i = 0; i < 1280; i++) stim[i] = $urandom;
    sent = 0; n_lim = 1280; base = out_cnt; n_last = 0;
    run(70, 60, 8000, "rand");
    check("rand_count", 64'(out_cnt - base), 64'(1280));
    check("rand_last_count", 64'(n_last), 64'(20));

    // Reset with one full bank holding output and 30 samples into the next.
    for (int i = 0; i < 94; i++) stim[i] = 32'(32'h100 + i);
    sent = 0; n_lim = 94;
    repeat (95) step(1'b1, 1'b0);
    check("mid_accepted", 64'(sent), 64'(94));
    check("mid_o_before", 64'(O), 64'(32'h100));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_o", 64'(O), 64'(0));
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_index", 64'(out_index), 64'(0));
    check("mid_rst_last", 64'(out_last), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 64; k++) stim[k] = 32'(32'h5000 + k);
    sent = 0; n_lim = 64;
    cap_o.delete(); cap_l.delete();
    run(100, 100, 500, "post_rst");
    check("post_rst_count", 64'(out_cnt), 64'(64));
    if (cap_o.size() == 64) begin
      check("post_rst_first", 64'(cap_o[0]), 64'(32'h5000));
      check("post_rst_third", 64'(cap_o[2]), 64'(32'h5008));
      check("post_rst_final", 64'(cap_o[63]), 64'(32'h503f));
    end else begin
      check("post_rst_capture", 64'(cap_o.size()), 64'(64));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
